// File: rtl/slice_carry_pkg.sv
// Shared types, widths and the golden-carry rule for the slice carry checker.
package slice_carry_pkg;

    localparam int unsigned OP_W     = 8;
    localparam int unsigned N_CARRY  = 4;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } state_t;

    // Carry k is bit 2k+2 of the zero-extended sum of the low 2k+2 operand bits plus cin.
    function automatic logic [N_CARRY-1:0] golden_carries(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b,
        input logic            cin
    );
        logic [N_CARRY-1:0] c;
        logic [OP_W-1:0]    mask;
        logic [OP_W:0]      sum;
        c = '0;
        for (int unsigned k = 0; k < N_CARRY; k++) begin
            mask = OP_W'((32'd1 << (2 * k + 2)) - 32'd1);
            sum  = {1'b0, a & mask} + {1'b0, b & mask} + {{OP_W{1'b0}}, cin};
            c[k] = sum[2 * k + 2];
        end
        return c;
    endfunction

endpackage

// File: rtl/slice_carry_checker_golden.sv
// Purely combinational reference carries for the operands currently held on the DUT bus.
module carry_golden_model
    import slice_carry_pkg::*;
(
    input  logic [OP_W-1:0]    a,
    input  logic [OP_W-1:0]    b,
    input  logic               cin,
    output logic [N_CARRY-1:0] golden
);

    // Golden carries straight from the shared rule
    always_comb begin
        golden = golden_carries(a, b, cin);
    end

endmodule

// File: rtl/slice_carry_checker.sv
// Drives one operand set into an external 4-output slice carry generator,
// waits a programmable settle time, samples its carries and scores them
// against the golden model.
module slice_carry_checker
    import slice_carry_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OP_W-1:0]    a_in,
    input  logic [OP_W-1:0]    b_in,
    input  logic               cin_in,
    input  logic               clear,
    output logic [OP_W-1:0]    dut_a,
    output logic [OP_W-1:0]    dut_b,
    output logic               dut_cin,
    input  logic [N_CARRY-1:0] dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_CARRY-1:0] mismatch,
    output logic [CNT_W-1:0]   test_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    state_t              state_q;
    state_t              state_d;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [N_CARRY-1:0]  golden;
    logic [N_CARRY-1:0]  golden_q;
    logic [N_CARRY-1:0]  cout_q;
    logic [N_CARRY-1:0]  mm_now;

    carry_golden_model u_golden (
        .a      (dut_a),
        .b      (dut_b),
        .cin    (dut_cin),
        .golden (golden)
    );

    assign busy   = (state_q != ST_IDLE);
    assign mm_now = cout_q ^ golden_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (settle_cnt <= SETTLE_W'(1)) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, settle timing, sampling and result reporting.
    // Results are registered on the edge leaving REPORT, so done is seen one
    // cycle after REPORT; clear is applied last so it wins over that update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_a      <= '0;
            dut_b      <= '0;
            dut_cin    <= 1'b0;
            settle_cnt <= '0;
            golden_q   <= '0;
            cout_q     <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            mismatch   <= '0;
            test_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dut_a   <= a_in;
                        dut_b   <= b_in;
                        dut_cin <= cin_in;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
                end
                ST_SAMPLE: begin
                    cout_q   <= dut_cout;
                    golden_q <= golden;
                end
                ST_REPORT: begin
                    done     <= 1'b1;
                    pass     <= (mm_now == '0);
                    mismatch <= mm_now;
                    if (test_cnt != '1) test_cnt <= test_cnt + CNT_W'(1);
                    if ((mm_now != '0) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
                end
                default: ;
            endcase
            if (clear) begin
                test_cnt <= '0;
                err_cnt  <= '0;
            end
        end
    end

endmodule
